// File: rtl/lamp_dimmer.sv
// Multi-channel LED dimmer: shared PWM counter, blink and breathe-step dividers,
// and one lamp_dimmer_ch lane per channel holding its mode, level and breathe ramp.

module lamp_dimmer_ch #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_mode,
    input  logic [PW-1:0] wr_level,
    input  logic          step_tick,
    input  logic          blink_phase,
    input  logic          pwm_wrap,
    input  logic [PW-1:0] pwm_cnt,
    output logic          led
);
    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_STATIC  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic [0:0] ST_UP   = 1'b0;
    localparam logic [0:0] ST_DOWN = 1'b1;

    logic [1:0]    mode;
    logic [PW-1:0] level;
    logic [PW-1:0] ramp;
    logic [0:0]    state;
    logic [PW-1:0] duty;
    logic [PW-1:0] target;

    always_comb begin
        target = '0;
        case (mode)
            MODE_STATIC:  target = level;
            MODE_BLINK:   target = blink_phase ? level : '0;
            MODE_BREATHE: target = ramp;
            default:      target = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode  <= MODE_OFF;
            level <= '0;
            ramp  <= '0;
            state <= ST_UP;
            duty  <= '0;
            led   <= 1'b0;
        end else begin
            led <= (pwm_cnt < duty);
            // Duty only changes at period start so a PWM period is never cut short.
            if (pwm_wrap)
                duty <= target;
            if (wr_en) begin
                mode  <= wr_mode;
                level <= wr_level;
                if (wr_mode == MODE_BREATHE) begin
                    ramp  <= '0;
                    state <= ST_UP;
                end
            end else if (mode == MODE_BREATHE && step_tick) begin
                if (state == ST_UP) begin
                    if (ramp < level) begin
                        ramp <= ramp + PW'(1);
                    end else begin
                        state <= ST_DOWN;
                        ramp  <= level;
                    end
                end else begin
                    if (ramp != '0)
                        ramp <= ramp - PW'(1);
                    else
                        state <= ST_UP;
                end
            end
        end
    end
endmodule

module lamp_dimmer #(
    parameter int c_freq     = 12000000,
    parameter int c_channels = 2,
    parameter int c_pwm_bits = 8,
    parameter int c_blink_hz = 1,
    parameter int c_step_hz  = 512,
    localparam int CW = (c_channels > 1) ? $clog2(c_channels) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [CW-1:0]         i_ch,
    input  logic [1:0]            i_mode,
    input  logic [c_pwm_bits-1:0] i_level,
    output logic [c_channels-1:0] o_led,
    output logic                  o_ack,
    output logic                  o_err
);
    localparam int PW        = c_pwm_bits;
    localparam int BLINK_DIV = c_freq / (2 * c_blink_hz);
    localparam int STEP_DIV  = c_freq / c_step_hz;
    localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [CW:0]   NUM_CH     = (CW + 1)'(c_channels);

    typedef struct packed {
        logic [1:0]    mode;
        logic [PW-1:0] level;
    } wr_req_t;

    wr_req_t             wr_req;
    logic                wr_ok;
    logic [c_channels-1:0] wr_hit;
    logic [PW-1:0]       pwm_cnt;
    logic [BW-1:0]       blink_cnt;
    logic [SW-1:0]       step_cnt;
    logic                blink_phase;
    logic                step_tick;
    logic                pwm_wrap;

    assign wr_req    = '{mode: i_mode, level: i_level};
    assign wr_ok     = i_wr && ({1'b0, i_ch} < NUM_CH);
    assign step_tick = (step_cnt == STEP_LAST);
    assign pwm_wrap  = &pwm_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            step_cnt    <= '0;
            o_ack       <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PW'(1);
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            step_cnt <= step_tick ? '0 : step_cnt + SW'(1);
            o_ack    <= wr_ok;
            o_err    <= i_wr && !wr_ok;
        end
    end

    for (genvar k = 0; k < c_channels; k++) begin : g_ch
        assign wr_hit[k] = wr_ok && (i_ch == CW'(k));

        lamp_dimmer_ch #(.PW(PW)) u_ch (
            .clk         (i_clk),
            .rst         (i_rst),
            .wr_en       (wr_hit[k]),
            .wr_mode     (wr_req.mode),
            .wr_level    (wr_req.level),
            .step_tick   (step_tick),
            .blink_phase (blink_phase),
            .pwm_wrap    (pwm_wrap),
            .pwm_cnt     (pwm_cnt),
            .led         (o_led[k])
        );
    end
endmodule

// File: tb/tb_lamp_dimmer.sv
// Directed bench for lamp_dimmer: 16-cycle PWM periods, 800-cycle blink windows,
// 16-cycle breathe steps; a second single-channel instance exercises rejected writes.

module tb_lamp_dimmer;
    localparam logic [1:0] M_OFF = 2'd0, M_STATIC = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;

    logic       clk = 1'b0;
    logic       rst, wr, a_wr;
    logic [0:0] ch, a_ch;
    logic [1:0] mode, a_mode;
    logic [3:0] level, a_level;
    logic [1:0] led;
    logic [0:0] a_led;
    logic       ack, err, a_ack, a_err;

    int cyc;
    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_br[8] = '{0, 1, 2, 3, 3, 2, 1, 0};

    always #5 clk = ~clk;

    // Edges since reset release; the DUT's PWM counter equals cyc mod 16.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    lamp_dimmer #(.c_freq(1600), .c_channels(2), .c_pwm_bits(4), .c_blink_hz(1), .c_step_hz(100)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_ch(ch), .i_mode(mode), .i_level(level),
        .o_led(led), .o_ack(ack), .o_err(err)
    );

    lamp_dimmer #(.c_freq(1600), .c_channels(1), .c_pwm_bits(4), .c_blink_hz(1), .c_step_hz(100)) dut_one (
        .i_clk(clk), .i_rst(rst), .i_wr(a_wr), .i_ch(a_ch), .i_mode(a_mode), .i_level(a_level),
        .o_led(a_led), .o_ack(a_ack), .o_err(a_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ends right after a wrap edge; the next 16 cycles of o_led form one period.
    task automatic align();
        do step(); while (cyc % 16 != 0);
    endtask

    task automatic measure(output int h0, output int h1, output int ha);
        h0 = 0; h1 = 0; ha = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            h0 += int'(led[0]);
            h1 += int'(led[1]);
            ha += int'(a_led[0]);
        end
    endtask

    task automatic write(input logic [0:0] c, input logic [1:0] m, input logic [3:0] l);
        wr = 1'b1; ch = c; mode = m; level = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total_cnt++;
            if ({led, ack, err, a_led, a_ack, a_err} !== 7'b0)
                $display("FAIL reset_hold i=%0d got led=%b ack=%b err=%b aled=%b want 0", i, led, ack, err, a_led);
            else pass_cnt++;
        end
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            step();
            total_cnt++;
            if ({led, ack, err} !== 4'b0)
                $display("FAIL idle_after_reset i=%0d got led=%b ack=%b err=%b want 0", i, led, ack, err);
            else pass_cnt++;
        end
    endtask

    task automatic test_static();
        int h0, h1, ha;
        write(0, M_STATIC, 4'd4);
        step();
        total_cnt++;
        if (ack !== 1'b1 || err !== 1'b0) $display("FAIL static_ack got ack=%b err=%b want 1/0", ack, err);
        else pass_cnt++;
        wr = 1'b0;
        step();
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL static_ack_pulse got ack=%b want 0", ack);
        else pass_cnt++;
        align();
        for (int p = 0; p < 2; p++) begin
            measure(h0, h1, ha);
            total_cnt++;
            if (h0 != 4 || h1 != 0) $display("FAIL static_duty p=%0d got h0=%0d h1=%0d want 4/0", p, h0, h1);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_zero();
        int h0, h1, ha;
        write(1, M_STATIC, 4'd15);
        step();
        total_cnt++;
        if (ack !== 1'b1) $display("FAIL full_ack got %b want 1", ack);
        else pass_cnt++;
        wr = 1'b0;
        align();
        measure(h0, h1, ha);
        total_cnt++;
        if (h1 != 15 || h0 != 4) $display("FAIL full_duty got h1=%0d h0=%0d want 15/4", h1, h0);
        else pass_cnt++;
        // Level 0 written mid-period; that period must still run at 15/16.
        h0 = 0; h1 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) write(1, M_STATIC, 4'd0);
            else wr = 1'b0;
            step();
            h0 += int'(led[0]);
            h1 += int'(led[1]);
            if (i == 5) begin
                total_cnt++;
                if (ack !== 1'b1) $display("FAIL zero_ack got %b want 1", ack);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (h1 != 15 || h0 != 4) $display("FAIL no_truncate got h1=%0d h0=%0d want 15/4", h1, h0);
        else pass_cnt++;
        for (int p = 0; p < 2; p++) begin
            measure(h0, h1, ha);
            total_cnt++;
            if (h1 != 0) $display("FAIL zero_duty p=%0d got h1=%0d want 0", p, h1);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int h0, h1, ha;
        write(0, M_STATIC, 4'd6);
        step();
        total_cnt++;
        if (ack !== 1'b1) $display("FAIL b2b_ack0 got %b want 1", ack);
        else pass_cnt++;
        write(0, M_STATIC, 4'd2);
        step();
        total_cnt++;
        if (ack !== 1'b1) $display("FAIL b2b_ack1 got %b want 1", ack);
        else pass_cnt++;
        write(1, M_STATIC, 4'd9);
        step();
        total_cnt++;
        if (ack !== 1'b1) $display("FAIL b2b_ack2 got %b want 1", ack);
        else pass_cnt++;
        wr = 1'b0;
        step();
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL b2b_ack_end got %b want 0", ack);
        else pass_cnt++;
        align();
        measure(h0, h1, ha);
        total_cnt++;
        if (h0 != 2 || h1 != 9) $display("FAIL b2b_duty got h0=%0d h1=%0d want 2/9", h0, h1);
        else pass_cnt++;
    endtask

    task automatic test_blink();
        int h0, h1, ha, k, exp_h;
        bit saw_on, saw_off;
        saw_on = 0; saw_off = 0;
        write(0, M_BLINK, 4'd8);
        step();
        wr = 1'b0;
        align();
        for (int p = 0; p < 110; p++) begin
            k = cyc;
            exp_h = (((k - 1) / 800) % 2 == 1) ? 8 : 0;
            measure(h0, h1, ha);
            if (exp_h == 8) saw_on = 1; else saw_off = 1;
            total_cnt++;
            if (h0 != exp_h || h1 != 9)
                $display("FAIL blink p=%0d k=%0d got h0=%0d h1=%0d want %0d/9", p, k, h0, h1, exp_h);
            else pass_cnt++;
        end
        total_cnt++;
        if (!(saw_on && saw_off)) $display("FAIL blink_span got on=%0d off=%0d want 1/1", saw_on, saw_off);
        else pass_cnt++;
    endtask

    task automatic check_breathe(input string tag, input int periods);
        int h0, h1, ha;
        for (int p = 0; p < periods; p++) begin
            measure(h0, h1, ha);
            total_cnt++;
            if (h1 != exp_br[p % 8]) $display("FAIL %s p=%0d got h1=%0d want %0d", tag, p, h1, exp_br[p % 8]);
            else pass_cnt++;
        end
    endtask

    task automatic test_breathe();
        align();
        write(1, M_BREATHE, 4'd3);
        step();
        total_cnt++;
        if (ack !== 1'b1) $display("FAIL breathe_ack got %b want 1", ack);
        else pass_cnt++;
        wr = 1'b0;
        align();
        check_breathe("breathe", 16);
    endtask

    task automatic test_invalid();
        int h0, h1, ha;
        a_wr = 1'b1; a_ch = 1'b0; a_mode = M_STATIC; a_level = 4'd4;
        step();
        total_cnt++;
        if (a_ack !== 1'b1 || a_err !== 1'b0) $display("FAIL inv_setup got ack=%b err=%b want 1/0", a_ack, a_err);
        else pass_cnt++;
        a_ch = 1'b1; a_level = 4'd15;
        step();
        total_cnt++;
        if (a_err !== 1'b1 || a_ack !== 1'b0) $display("FAIL inv_err got err=%b ack=%b want 1/0", a_err, a_ack);
        else pass_cnt++;
        a_wr = 1'b0;
        step();
        total_cnt++;
        if (a_err !== 1'b0 || a_ack !== 1'b0) $display("FAIL inv_pulse got err=%b ack=%b want 0/0", a_err, a_ack);
        else pass_cnt++;
        align();
        measure(h0, h1, ha);
        total_cnt++;
        if (ha != 4) $display("FAIL inv_unchanged got ha=%0d want 4", ha);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int h0, h1, ha;
        step();
        rst = 1'b1;
        write(0, M_STATIC, 4'd15);
        step();
        total_cnt++;
        if ({led, ack, err, a_led} !== 5'b0)
            $display("FAIL rst_mid got led=%b ack=%b err=%b aled=%b want 0", led, ack, err, a_led);
        else pass_cnt++;
        rst = 1'b0;
        wr = 1'b0;
        step();
        total_cnt++;
        if (ack !== 1'b0 || err !== 1'b0) $display("FAIL rst_discard got ack=%b err=%b want 0/0", ack, err);
        else pass_cnt++;
        align();
        measure(h0, h1, ha);
        total_cnt++;
        if (h0 != 0 || h1 != 0 || ha != 0) $display("FAIL rst_cleared got h0=%0d h1=%0d ha=%0d want 0", h0, h1, ha);
        else pass_cnt++;
        write(1, M_BREATHE, 4'd3);
        step();
        wr = 1'b0;
        align();
        check_breathe("breathe_restart", 8);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; ch = 1'b0; mode = M_OFF; level = 4'd0;
        a_wr = 1'b0; a_ch = 1'b0; a_mode = M_OFF; a_level = 4'd0;
        test_reset();
        test_static();
        test_full_zero();
        test_back_to_back();
        test_blink();
        test_breathe();
        test_invalid();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
